// File: rtl/block_core.sv
// Registered 3-input population counter: out is the number of ones among {a,b,c}
// sampled LATENCY rising edges earlier (the sampling edge counts as the first).
module block_core #(
  parameter int unsigned LATENCY = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,  // active-high synchronous reset despite the name
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic [1:0] out
);

  if (LATENCY == 1) begin : g_lat1
    logic [1:0] w_sum;
    logic [1:0] r_out;

    assign w_sum = {1'b0, a} + {1'b0, b} + {1'b0, c};

    always_ff @(posedge Clk) begin
      if (Rst_n) begin
        r_out <= 2'b00;
      end else begin
        r_out <= w_sum;
      end
    end

    assign out = r_out;
  end else begin : g_latn
    logic [2:0] r_abc;
    logic [1:0] w_sum;
    // Sum stages; the last entry is the output register.
    logic [1:0] r_sum [LATENCY-1];

    assign w_sum = {1'b0, r_abc[2]} + {1'b0, r_abc[1]} + {1'b0, r_abc[0]};

    always_ff @(posedge Clk) begin
      if (Rst_n) begin
        r_abc <= 3'b000;
        for (int unsigned i = 0; i < LATENCY - 1; i++) begin
          r_sum[i] <= 2'b00;
        end
      end else begin
        r_abc    <= {a, b, c};
        r_sum[0] <= w_sum;
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          r_sum[i] <= r_sum[i-1];
        end
      end
    end

    assign out = r_sum[LATENCY-2];
  end

endmodule

// File: tb/tb_block_core.sv
// Self-checking bench for block_core at LATENCY 1, 2 and 4 against a history-based
// reference model: out after edge k is the popcount of edge k-L+1 unless a reset intervened.
module tb_block_core;

  logic       Clk;
  logic       Rst_n;
  logic       a;
  logic       b;
  logic       c;
  logic [1:0] out1;
  logic [1:0] out2;
  logic [1:0] out4;

  int n_checks;
  int n_errors;
  int n_edges;

  logic [2:0] h_in  [4096];
  bit         h_rst [4096];

  block_core #(.LATENCY(1)) u_dut1 (.Clk(Clk), .Rst_n(Rst_n), .a(a), .b(b), .c(c), .out(out1));
  block_core #(.LATENCY(2)) u_dut2 (.Clk(Clk), .Rst_n(Rst_n), .a(a), .b(b), .c(c), .out(out2));
  block_core #(.LATENCY(4)) u_dut4 (.Clk(Clk), .Rst_n(Rst_n), .a(a), .b(b), .c(c), .out(out4));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [1:0] model(int lat, int k);
    int src;
    src = k - lat + 1;
    for (int j = src; j <= k; j++) begin
      if (j < 0 || h_rst[j]) return 2'd0;
    end
    return 2'($countones(h_in[src]));
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge with the given reset/input values; optionally glitches a afterwards.
  task automatic step(input bit rst, input logic [2:0] v, input bit glitch);
    Rst_n       = rst;
    {a, b, c}   = v;
    @(posedge Clk);
    h_rst[n_edges] = rst;
    h_in[n_edges]  = v;
    #1;
    chk($sformatf("lat1_edge%0d", n_edges), out1, model(1, n_edges));
    chk($sformatf("lat2_edge%0d", n_edges), out2, model(2, n_edges));
    chk($sformatf("lat4_edge%0d", n_edges), out4, model(4, n_edges));
    if (glitch) begin
      a = ~v[2];
      #2;
      a = v[2];
    end
    n_edges++;
  endtask

  initial begin
    bit         rst;
    logic [2:0] v;
    n_checks = 0;
    n_errors = 0;
    n_edges  = 0;
    Rst_n    = 1'b1;
    {a, b, c} = 3'b111;

    // Reset held with all inputs high, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 3'b111, 1'b0);
    chk("reset_hold_lat2", out2, 2'd0);

    // Exhaustive sweep.
    for (int i = 0; i < 8; i++) step(1'b0, 3'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 1'b0);

    // Back-to-back alternating streaming.
    for (int i = 0; i < 10; i++) step(1'b0, (i % 2 == 0) ? 3'b111 : 3'b000, 1'b0);

    // Mid-stream reset with X on inputs during reset.
    for (int i = 0; i < 5; i++) step(1'b0, 3'b111, 1'b0);
    step(1'b1, 3'bxxx, 1'b0);
    chk("midreset_lat2_at_reset", out2, 2'd0);
    step(1'b0, 3'b111, 1'b0);
    chk("midreset_lat2_release1", out2, 2'd0);
    step(1'b0, 3'b111, 1'b0);
    chk("midreset_lat2_release2", out2, 2'd3);
    for (int i = 0; i < 4; i++) step(1'b0, 3'b111, 1'b0);

    // Glitch immunity: a toggles between edges but is 0 at every edge.
    for (int i = 0; i < 8; i++) step(1'b0, 3'b000, 1'b1);

    // Single 110 sample to check each latency's arrival edge.
    step(1'b1, 3'b000, 1'b0);
    step(1'b0, 3'b110, 1'b0);
    chk("lat1_110_edge1", out1, 2'd2);
    step(1'b0, 3'b000, 1'b0);
    chk("lat2_110_edge2", out2, 2'd2);
    step(1'b0, 3'b000, 1'b0);
    step(1'b0, 3'b000, 1'b0);
    chk("lat4_110_edge4", out4, 2'd2);

    // Randomized streaming with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      v   = 3'($urandom);
      if (rst && $urandom_range(0, 1) == 1) v = 3'bxxx;
      step(rst, v, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/block_core.md
Name: block_core

Overview:
- Registered 3-input population counter: samples single-bit inputs a, b, c each clock and reports how many are high (0..3) on the 2-bit output out.
- Models the classic 3-input adder/majority datapath stage: a fixed-latency, flushable pipeline.
- Sits between bit-level control sources and downstream logic that needs an encoded count.
- Latency is configurable at elaboration.

Parameters:
- LATENCY, 2, clock cycles from input sampling edge to out update; legal range 1..4; out valid LATENCY edges after inputs are sampled.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Rst_n  input  1  synchronous reset, ACTIVE-HIGH despite the name; sampled on Clk rising edge.
- a  input  1  data bit 0.
- b  input  1  data bit 1.
- c  input  1  data bit 2.
- out  output  2  registered count of ones among {a,b,c} from LATENCY cycles earlier.

Behaviour:
- Reset and clock:
  - One clock domain (Clk); no asynchronous logic; no combinational path from any input to out.
  - Reset: on any rising Clk edge with Rst_n==1, every pipeline register and out are cleared to 2'b00.
  - Reset takes priority over data capture on the same edge.
- Data path:
  - Stage 1 registers a, b, c unchanged.
  - The sum a+b+c is computed as an unsigned 2-bit value; max 3, no overflow.
  - The sum propagates through the remaining LATENCY-1 register stages; the final stage drives out.
  - For LATENCY==1: out <= a+b+c directly on the sampling edge.
- Timing:
  - Inputs sampled at edge N (Rst_n==0) appear on out just after edge N+LATENCY-1.
  - Example: LATENCY=2, inputs at edge 0 appear after edge 1.
  - Continuous streaming: one new result per cycle; no stalls, no handshake, no valid signal.
- Reset behaviour at the boundaries:
  - Reset release: on the first edge with Rst_n==0, stage 1 captures inputs while later stages still hold 0.
  - out therefore stays 0 until that first sample reaches the output.
  - Reset mid-operation: all in-flight samples are discarded (pipeline flush). out is 0 from the reset edge until LATENCY edges after release.
  - Reset held for multiple cycles: out stays 0 throughout.
- Count encoding:
  - 00 = no inputs high; 01 = one high; 10 = two high; 11 = all three high.
  - out[1] equals majority(a,b,c); out[0] equals a^b^c (same latency).
- Other rules:
  - Input changes between clock edges have no effect; only edge-sampled values matter.
  - X/Z on inputs while Rst_n==1 must not affect the state after reset.
  - All registers use nonblocking assignment semantics: the stage-to-stage shift must never collapse into a single cycle, whatever the statement order.

Test Plan:
- Reset hold: Rst_n=1 for 3 edges with a=b=c=1 -> out==00 throughout and for 1 edge after release (LATENCY=2).
- Exhaustive sweep: after reset, drive {a,b,c}=000,001,...,111, one per cycle -> out sequence 0,1,1,2,1,2,2,3, each lagging its input by exactly 2 edges.
- Back-to-back streaming: alternate 111 and 000 every cycle -> out alternates 3,0 each cycle with no bubbles once filled.
- Mid-stream reset: stream 111, assert Rst_n for 1 edge, then continue 111 -> out==0 from the reset edge, returns to 3 on the 2nd edge after release.
- Glitch immunity: toggle a between edges while holding it 0 at every rising edge, b=c=0 -> out stays 0.
- Parameter check: LATENCY=1, input 110 -> out==2 after the very next edge; LATENCY=4 -> out==2 after the 4th edge.
